serial_sub_22bit: RTL
=====================

SERIAL_SUB_22BIT -- requirements
Module: serial_sub_22bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 22, operand width in bits.
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit, synchronous active-low reset, sampled on the i_clk rising edge.
REQ-004 The block SHALL have port i_start, input, 1 bit, request to begin a subtraction.
REQ-005 The block SHALL have port i_sub_term1, input, WIDTH bits, minuend, sampled only on an accepted start.
REQ-006 The block SHALL have port i_sub_term2, input, WIDTH bits, subtrahend, sampled only on an accepted start.
REQ-007 The block SHALL have port o_busy, output, 1 bit, high while a subtraction is in progress.
REQ-008 The block SHALL have port o_done, output, 1 bit, one-cycle completion pulse.
REQ-009 The block SHALL have port o_result, output, WIDTH+1 bits: [WIDTH-1:0] = difference mod 2^WIDTH; [WIDTH] = borrow-out (1 iff i_sub_term1 < i_sub_term2, unsigned).

Function
REQ-010 The block SHALL implement a bit-serial ripple-borrow subtractor processing one bit per clock, LSB first.
REQ-011 The FSM SHALL have states IDLE, RUN, DONE.
REQ-012 Start acceptance: i_start=1 at a rising edge while state is IDLE or DONE; the block SHALL capture both operands, clear the borrow, clear the bit counter, and enter RUN.
REQ-013 i_start while in RUN SHALL be ignored; operands and progress stay unaffected.
REQ-014 In RUN, on each edge, the block SHALL compute d = a0 ^ b0 ^ bw and bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw), where a0 and b0 are the current LSBs of the operand shift registers.
REQ-015 In RUN, the block SHALL shift d into an internal difference register, shift both operand registers right, and increment the counter.
REQ-016 After exactly WIDTH RUN edges the FSM SHALL go to DONE.
REQ-017 o_result SHALL load {bw_final, difference} on that same edge.
REQ-018 o_busy SHALL be 1 exactly in RUN.
REQ-019 o_done SHALL be 1 exactly in DONE, which lasts one cycle.
REQ-020 From DONE the FSM SHALL go to IDLE, or to RUN if a start is accepted.
REQ-021 Latency: o_done SHALL be high in the cycle following the (WIDTH+1)th rising edge counted from the accepting edge (edge 0), i.e. 23 edges for WIDTH=22.
REQ-022 o_result SHALL hold its value from the DONE entry until the next completion or reset; intermediate bits SHALL never be visible on o_result.
REQ-023 Back-to-back starts (start in the DONE cycle) SHALL be accepted with no idle gap.
REQ-024 Arithmetic SHALL be unsigned, and the result SHALL be bit-exact to {i_sub_term1 < i_sub_term2, (i_sub_term1 - i_sub_term2) mod 2^WIDTH}.

Reset
REQ-025 While i_rst_n=0 at an edge, state SHALL become IDLE and o_busy, o_done, o_result, counter, borrow and shift registers SHALL be cleared to 0.
REQ-026 Reset SHALL take priority over i_start and over any in-progress operation.
REQ-027 Reset mid-RUN SHALL abort the operation with no o_done pulse.
REQ-028 After reset release, the first start SHALL behave as from power-up.

Verification
REQ-029 Basic: reset, then start with 5 - 3 -> o_done 23 edges later, o_result = 23'h000002; o_busy high for 22 cycles.
REQ-030 Underflow: 0 - 1 -> o_result = 23'h7FFFFF (borrow=1, diff=22'h3FFFFF).
REQ-031 Equal/max: 22'h3FFFFF - 22'h3FFFFF -> 23'h000000; then 22'h3FFFFF - 0 -> 23'h3FFFFF.
REQ-032 Ignored start: start 100 - 40, then during RUN cycle 5 pulse start with 1 - 2 -> single o_done, o_result = 23'h00003C, second request dropped.
REQ-033 Reset mid-op: start 7 - 9, assert i_rst_n=0 at RUN cycle 10 -> o_busy=0, o_done never pulses, o_result=0; a following 9 - 7 yields 23'h000002.
REQ-034 Back-to-back plus random: start in each DONE cycle for 1000 random operand pairs -> every result matches the reference model, with 23-edge spacing between o_done pulses.

Source files
------------

// File: rtl/serial_sub_22bit.sv
// Bit-serial ripple-borrow subtractor. It handles one bit per clock, LSB first.
//   i_clk        : clock; all state updates happen on its rising edge
//   i_rst_n      : synchronous active-low reset
//   i_start      : begin a subtraction (accepted in IDLE or DONE, ignored in RUN)
//   i_sub_term1  : minuend, captured when a start is accepted
//   i_sub_term2  : subtrahend, captured when a start is accepted
//   o_busy       : high while in RUN
//   o_done       : one-cycle pulse when the result is ready
//   o_result     : {borrow_out, difference}; held until the next completion or reset
module serial_sub_22bit #(
  parameter int WIDTH = 22
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH:0]   o_result
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             bw;
  logic [CW-1:0]    cnt;

  // One full-subtractor cell working on the current LSBs.
  logic a0, b0, d, bw_next;
  assign a0      = a_sr[0];
  assign b0      = b_sr[0];
  assign d       = a0 ^ b0 ^ bw;
  assign bw_next = (~a0 & b0) | (~(a0 ^ b0) & bw);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      diff_sr  <= '0;
      bw       <= 1'b0;
      cnt      <= '0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
      o_result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state   <= RUN;
            a_sr    <= i_sub_term1;
            b_sr    <= i_sub_term2;
            diff_sr <= '0;
            bw      <= 1'b0;
            cnt     <= '0;
            o_busy  <= 1'b1;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB, so after WIDTH shifts
          // bit 0 of the result sits at diff_sr[0].
          diff_sr <= {d, diff_sr[WIDTH-1:1]};
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          bw      <= bw_next;
          cnt     <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            // The last bit is merged in directly. This lets o_result update on
            // the same edge that enters DONE, and the output never carries a
            // partial difference.
            state    <= DONE;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_result <= {bw_next, d, diff_sr[WIDTH-1:1]};
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
